// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - access size encoding and byte-lane helpers for the data memory arbiter
// Purpose : shared types and pure functions used by dmem_arbiter.
// Contents: size_e   - access size (SZ_B=0, SZ_H=1, SZ_W=2; 3 is illegal)
//           lane_be  - byte write-enable mask for a size at a byte offset
//           fmt_load - lane select plus sign/zero extension of a read word
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [1:0] SZ_ILL = 2'd3;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    res = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    res = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-way round-robin grant with last-grant register
// Purpose : picks one of two requesters when enabled; remembers the last winner.
// Ports   : clk, rst_n        clock, async active-low reset
//           i_en              grant allowed this cycle
//           i_req0, i_req1    requests
//           o_gnt0, o_gnt1    one-hot (or zero) grant, combinational
// FIXED_PRI=1 makes port 0 win every contest.
module dmem_rr_arb #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // Reset value 1 means port 0 wins the first contest.
  logic r_last_grant;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        if (FIXED_PRI || r_last_grant) o_gnt0 = 1'b1;
        else                           o_gnt1 = 1'b1;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last_grant <= 1'b1;
    else if (o_gnt0) r_last_grant <= 1'b0;
    else if (o_gnt1) r_last_grant <= 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and access formatter for the single-port data memory
// Purpose : grants one requester per two cycles, checks alignment/range, drives byte
//           lanes to the memory and returns formatted load data one cycle later.
// Ports   : clk, rst_n                          clock, async active-low reset
//           pN_req_valid/ready/we/size/uns/addr/wdata  request side, N = 0,1
//           pN_resp_valid/rdata/err             one-cycle response
//           mem_en/be/addr/wdata, mem_rdata     memory macro (1-cycle read latency)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned WORD_AW   = 15,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               p0_req_valid,
  output logic               p0_req_ready,
  input  logic               p0_req_we,
  input  logic [1:0]         p0_req_size,
  input  logic               p0_req_uns,
  input  logic [31:0]        p0_req_addr,
  input  logic [31:0]        p0_req_wdata,
  output logic               p0_resp_valid,
  output logic [31:0]        p0_resp_rdata,
  output logic               p0_resp_err,
  input  logic               p1_req_valid,
  output logic               p1_req_ready,
  input  logic               p1_req_we,
  input  logic [1:0]         p1_req_size,
  input  logic               p1_req_uns,
  input  logic [31:0]        p1_req_addr,
  input  logic [31:0]        p1_req_wdata,
  output logic               p1_resp_valid,
  output logic [31:0]        p1_resp_rdata,
  output logic               p1_resp_err,
  output logic               mem_en,
  output logic [3:0]         mem_be,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e      r_state, w_state_nxt;
  logic        w_gnt0, w_gnt1, w_grant;
  logic        w_we, w_uns, w_err, w_misalign, w_oor;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_rdata;
  logic        w_resp_valid;

  logic        r_port, r_we, r_uns, r_err;
  logic [1:0]  r_size, r_off;

  dmem_rr_arb #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == ST_IDLE),
    .i_req0 (p0_req_valid),
    .i_req1 (p1_req_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign w_grant      = w_gnt0 | w_gnt1;
  assign p0_req_ready = w_gnt0;
  assign p1_req_ready = w_gnt1;

  // Granted request (port 1 only when it holds the grant).
  assign w_we    = w_gnt1 ? p1_req_we    : p0_req_we;
  assign w_size  = w_gnt1 ? p1_req_size  : p0_req_size;
  assign w_uns   = w_gnt1 ? p1_req_uns   : p0_req_uns;
  assign w_addr  = w_gnt1 ? p1_req_addr  : p0_req_addr;
  assign w_wdata = w_gnt1 ? p1_req_wdata : p0_req_wdata;

  assign w_misalign = (w_size == SZ_ILL) ||
                      ((w_size == SZ_H) && w_addr[0]) ||
                      ((w_size == SZ_W) && (w_addr[1:0] != 2'b00));
  // Any byte-address bit above the memory's word range makes the access out of range.
  assign w_oor = |(w_addr >> (WORD_AW + 2));
  assign w_err = w_misalign | w_oor;

  assign mem_addr = w_addr[WORD_AW+1:2];

  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_be      = 4'b0000;
    mem_wdata   = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_BUSY;
          if (!w_err) begin
            mem_en = 1'b1;
            if (w_we) begin
              mem_be = lane_be(w_size, w_addr[1:0]);
              // Replication puts the data on every lane so be alone selects the target.
              case (w_size)
                SZ_B:    mem_wdata = {4{w_wdata[7:0]}};
                SZ_H:    mem_wdata = {2{w_wdata[15:0]}};
                default: mem_wdata = w_wdata;
              endcase
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_off   <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_grant) begin
        r_port <= w_gnt1;
        r_we   <= w_we;
        r_size <= w_size;
        r_uns  <= w_uns;
        r_off  <= w_addr[1:0];
        r_err  <= w_err;
      end
    end
  end

  assign w_resp_valid = (r_state == ST_BUSY);
  assign w_rdata      = (!r_we && !r_err) ? fmt_load(mem_rdata, r_off, r_size, r_uns) : 32'h0;

  assign p0_resp_valid = w_resp_valid && !r_port;
  assign p1_resp_valid = w_resp_valid &&  r_port;
  assign p0_resp_err   = p0_resp_valid && r_err;
  assign p1_resp_err   = p1_resp_valid && r_err;
  assign p0_resp_rdata = p0_resp_valid ? w_rdata : 32'h0;
  assign p1_resp_rdata = p1_resp_valid ? w_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int unsigned AW = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        p0_req_valid, p0_req_we, p0_req_uns;
  logic [1:0]  p0_req_size;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p1_req_valid, p1_req_we, p1_req_uns;
  logic [1:0]  p1_req_size;
  logic [31:0] p1_req_addr, p1_req_wdata;

  logic          p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid, p0_resp_err, p1_resp_err;
  logic [31:0]   p0_resp_rdata, p1_resp_rdata;
  logic          mem_en;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic          fx_p0_req_ready, fx_p1_req_ready, fx_p0_resp_valid, fx_p1_resp_valid;
  logic          fx_p0_resp_err, fx_p1_resp_err, fx_mem_en;
  logic [31:0]   fx_p0_resp_rdata, fx_p1_resp_rdata, fx_mem_wdata;
  logic [3:0]    fx_mem_be;
  logic [AW-1:0] fx_mem_addr;

  dmem_arbiter #(.WORD_AW(AW), .FIXED_PRI(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_uns(p0_req_uns), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p0_resp_err(p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_uns(p1_req_uns), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .p1_resp_err(p1_resp_err),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.WORD_AW(AW), .FIXED_PRI(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(fx_p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_uns(p0_req_uns), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_resp_valid(fx_p0_resp_valid), .p0_resp_rdata(fx_p0_resp_rdata),
    .p0_resp_err(fx_p0_resp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(fx_p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_uns(p1_req_uns), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_resp_valid(fx_p1_resp_valid), .p1_resp_rdata(fx_p1_resp_rdata),
    .p1_resp_err(fx_p1_resp_err),
    .mem_en(fx_mem_en), .mem_be(fx_mem_be), .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory macro model: byte-enabled write, registered read, driven by the round-robin DUT.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_be != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_addr[5:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  // Values captured during the most recent access.
  logic        c_en, c_v0, c_v1, c_err;
  logic [3:0]  c_be;
  logic [31:0] c_addr, c_wdata, c_rdata;

  task automatic access(input int port, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int  cyc;
    logic rdy;
    @(negedge clk);
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_size = size; p0_req_uns = uns;
      p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_size = size; p1_req_uns = uns;
      p1_req_addr = addr; p1_req_wdata = wdata;
    end
    #1;
    cyc = 0;
    rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    while (!rdy && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
      rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    end
    if (!rdy) begin
      check("grant_timeout", 32'd0, 32'd1);
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      return;
    end
    c_en = mem_en; c_be = mem_be; c_addr = 32'(mem_addr); c_wdata = mem_wdata;
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    c_v0 = p0_resp_valid; c_v1 = p1_resp_valid;
    c_err   = (port == 0) ? p0_resp_err   : p1_resp_err;
    c_rdata = (port == 0) ? p0_resp_rdata : p1_resp_rdata;
  endtask

  task automatic expect_resp(input string tag, input int port, input logic err, input logic [31:0] rdata);
    check({tag, "_v0"},  32'(c_v0), 32'(port == 0));
    check({tag, "_v1"},  32'(c_v1), 32'(port == 1));
    check({tag, "_err"}, 32'(c_err), 32'(err));
    check({tag, "_rd"},  c_rdata, rdata);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
    rst_n = 1'b0;
    p0_req_valid = 0; p0_req_we = 0; p0_req_size = 0; p0_req_uns = 0; p0_req_addr = 0; p0_req_wdata = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_size = 0; p1_req_uns = 0; p1_req_addr = 0; p1_req_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_v0", 32'(p0_resp_valid), 0);
    check("rst_v1", 32'(p1_resp_valid), 0);
    check("rst_err0", 32'(p0_resp_err), 0);
    check("rst_rd0", p0_resp_rdata, 0);
    check("rst_en", 32'(mem_en), 0);
    check("rst_be", 32'(mem_be), 0);
    rst_n = 1'b1;

    // Word store then load
    access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_en", 32'(c_en), 1); check("sw_be", 32'(c_be), 32'hF);
    check("sw_addr", c_addr, 4);  check("sw_wd", c_wdata, 32'hDEADBEEF);
    expect_resp("sw", 0, 1'b0, 32'h0);
    access(0, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    check("lw_be", 32'(c_be), 0);
    expect_resp("lw", 0, 1'b0, 32'hDEADBEEF);

    // Sub-word load formatting on word 0x80FF0000
    access(0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h80FF0000);
    access(0, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0); expect_resp("lb",  0, 1'b0, 32'hFFFFFF80);
    access(0, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0); expect_resp("lbu", 0, 1'b0, 32'h00000080);
    access(0, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0); expect_resp("lh",  0, 1'b0, 32'hFFFF80FF);
    access(0, 1'b0, SZ_H, 1'b1, 32'h12, 32'h0); expect_resp("lhu", 0, 1'b0, 32'h000080FF);

    // Sub-word stores, read back through port 1
    access(0, 1'b1, SZ_B, 1'b0, 32'h21, 32'h000000AB);
    check("sb_be", 32'(c_be), 32'b0010); check("sb_wd", c_wdata, 32'hABABABAB);
    check("sb_addr", c_addr, 8);
    access(0, 1'b1, SZ_H, 1'b0, 32'h22, 32'h00001234);
    check("sh_be", 32'(c_be), 32'b1100); check("sh_wd", c_wdata, 32'h12341234);
    access(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    expect_resp("p1_lw", 1, 1'b0, 32'h1234AB00);

    // Error accesses never reach memory
    access(0, 1'b0, SZ_W, 1'b0, 32'h02, 32'h0);        check("e_lw_en", 32'(c_en), 0);
    expect_resp("e_lw", 0, 1'b1, 32'h0);
    access(0, 1'b0, SZ_H, 1'b0, 32'h01, 32'h0);        check("e_lh_en", 32'(c_en), 0);
    expect_resp("e_lh", 0, 1'b1, 32'h0);
    access(1, 1'b0, 2'd3, 1'b0, 32'h00, 32'h0);        check("e_sz_en", 32'(c_en), 0);
    expect_resp("e_sz", 1, 1'b1, 32'h0);
    access(0, 1'b0, SZ_W, 1'b0, 32'h0002_0000, 32'h0); check("e_oor_en", 32'(c_en), 0);
    expect_resp("e_oor", 0, 1'b1, 32'h0);
    access(0, 1'b1, SZ_W, 1'b0, 32'h0002_0020, 32'h55555555); check("e_sw_en", 32'(c_en), 0);
    access(1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    expect_resp("e_sw_kept", 1, 1'b0, 32'h1234AB00);

    // Reset during BUSY of a load: response dropped
    @(negedge clk);
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_size = SZ_W; p0_req_uns = 1'b0; p0_req_addr = 32'h10;
    #1 check("mr_ready", 32'(p0_req_ready), 1);
    @(posedge clk); #2;
    rst_n = 1'b0; p0_req_valid = 1'b0;
    @(negedge clk);
    check("mr_v0", 32'(p0_resp_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mr_after_v", 32'(p0_resp_valid | p1_resp_valid), 0);
    end

    // Both ports valid continuously: round-robin alternates from port 0; fixed priority starves port 1
    p0_req_valid = 1'b1; p0_req_we = 1'b0; p0_req_size = SZ_W; p0_req_addr = 32'h10;
    p1_req_valid = 1'b1; p1_req_we = 1'b0; p1_req_size = SZ_W; p1_req_addr = 32'h10;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        check("rr_rdy0", 32'(p0_req_ready), 32'((k / 2) % 2 == 0));
        check("rr_rdy1", 32'(p1_req_ready), 32'((k / 2) % 2 == 1));
        check("fx_rdy0", 32'(fx_p0_req_ready), 1);
        check("fx_rdy1", 32'(fx_p1_req_ready), 0);
      end else begin
        check("rr_v0", 32'(p0_resp_valid), 32'((k / 2) % 2 == 0));
        check("rr_v1", 32'(p1_resp_valid), 32'((k / 2) % 2 == 1));
        check("rr_rd", p0_resp_rdata | p1_resp_rdata, 32'h80FF0000);
        check("fx_v1", 32'(fx_p1_resp_valid), 0);
      end
      @(negedge clk);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
